multicycle_controller: RTL and testbench

- Sequencing FSM for the multi-cycle variant of the RV32I core.
- Each instruction walks through fetch, decode, execute, memory and writeback states. One shared ALU and one unified memory port serve all states.
- Produces per-cycle datapath selects and write strobes, stalls on memory wait states, and counts retired instructions.
- Sits between the instruction register / ALU flags and the datapath muxes. Replaces single-cycle decode for this core.

---
 rtl/multicycle_controller_pkg.sv | 45 ++++
 rtl/multicycle_controller_alu_decoder.sv | 24 ++
 rtl/multicycle_controller.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared state, opcode and datapath-select encodings for the multi-cycle RV32I controller.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        EXEC_R  = 4'd2,
        EXEC_I  = 4'd3,
        ALU_WB  = 4'd4,
        MEM_ADR = 4'd5,
        MEM_RD  = 4'd6,
        MEM_WB  = 4'd7,
        MEM_WR  = 4'd8,
        BEQ     = 4'd9,
        ILLEGAL = 4'd10
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational funct3/funct7 to ALU-op decode; flags unsupported funct3 as illegal.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_is_rtype,
    output logic [1:0] o_alu_control,
    output logic       o_legal
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_legal       = 1'b1;
        case (i_funct3)
            // funct7b5 only selects sub for register-register ops; there is no subi
            3'b000:  o_alu_control = (i_is_rtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  o_alu_control = ALU_AND;
            3'b110:  o_alu_control = ALU_OR;
            default: o_legal       = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: FETCH..WB states drive datapath selects and strobes.
// Memory states stall on !mem_ready; a watchdog turns long stalls into a sticky bus error.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic             i_funct7b5,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_pc_write,
    output logic             o_ir_write,
    output logic             o_adr_src,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_reg_write,
    output logic [1:0]       o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [1:0]       o_alu_control,
    output logic [1:0]       o_result_src,
    output logic [1:0]       o_imm_src,
    output logic [3:0]       o_state,
    output logic             o_illegal,
    output logic             o_bus_err,
    output logic [CNT_W-1:0] o_retired
);

    localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic              r_illegal;
    logic              r_bus_err;
    logic [CNT_W-1:0]  r_retired;

    logic [1:0] w_alu_op;
    logic       w_alu_legal;
    logic       w_waiting;
    logic       w_timeout;
    logic       w_retire;

    alu_decoder u_alu_decoder (
        .i_funct3      (i_funct3),
        .i_funct7b5    (i_funct7b5),
        .i_is_rtype    (r_state == EXEC_R),
        .o_alu_control (w_alu_op),
        .o_legal       (w_alu_legal)
    );

    assign w_waiting = ((r_state == FETCH) || (r_state == MEM_RD) || (r_state == MEM_WR)) && !i_mem_ready;
    assign w_timeout = (TIMEOUT != 0) && w_waiting && (r_wait == WAIT_LAST);
    assign w_retire  = (r_state == ALU_WB) || (r_state == MEM_WB) || (r_state == BEQ) ||
                       ((r_state == MEM_WR) && i_mem_ready);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= FETCH;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
            r_retired <= '0;
        end else begin
            if (w_retire)
                r_retired <= r_retired + 1'b1;
            // wait counter only survives self-loops, so it clears on every state change
            r_wait <= w_waiting ? r_wait + 1'b1 : '0;
            if (w_timeout) begin
                r_state   <= ILLEGAL;
                r_illegal <= 1'b1;
                r_bus_err <= 1'b1;
            end else begin
                case (r_state)
                    FETCH:   if (i_mem_ready) r_state <= DECODE;
                    DECODE: begin
                        case (i_opcode)
                            OP_RTYPE:          r_state <= EXEC_R;
                            OP_ITYPE:          r_state <= EXEC_I;
                            OP_LOAD, OP_STORE: r_state <= MEM_ADR;
                            OP_BRANCH:         r_state <= BEQ;
                            default: begin
                                r_state   <= ILLEGAL;
                                r_illegal <= 1'b1;
                            end
                        endcase
                    end
                    EXEC_R, EXEC_I: begin
                        if (w_alu_legal) begin
                            r_state <= ALU_WB;
                        end else begin
                            r_state   <= ILLEGAL;
                            r_illegal <= 1'b1;
                        end
                    end
                    MEM_ADR: r_state <= (i_opcode == OP_LOAD) ? MEM_RD : MEM_WR;
                    MEM_RD:  if (i_mem_ready) r_state <= MEM_WB;
                    MEM_WR:  if (i_mem_ready) r_state <= FETCH;
                    ALU_WB, MEM_WB, BEQ: r_state <= FETCH;
                    ILLEGAL: r_state <= ILLEGAL;
                    default: begin
                        r_state   <= ILLEGAL;
                        r_illegal <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        o_pc_write    = 1'b0;
        o_ir_write    = 1'b0;
        o_adr_src     = 1'b0;
        o_mem_read    = 1'b0;
        o_mem_write   = 1'b0;
        o_reg_write   = 1'b0;
        o_alu_src_a   = SRCA_PC;
        o_alu_src_b   = SRCB_RS2;
        o_alu_control = ALU_ADD;
        o_result_src  = RES_ALUOUT;
        o_imm_src     = IMM_I;
        case (r_state)
            FETCH: begin
                o_mem_read   = 1'b1;
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALU;
                o_ir_write   = i_mem_ready;
                o_pc_write   = i_mem_ready;
            end
            DECODE: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_IMM;
                o_imm_src   = IMM_B;
            end
            EXEC_R: begin
                o_alu_src_a   = SRCA_RS1;
                o_alu_control = w_alu_op;
            end
            EXEC_I: begin
                o_alu_src_a   = SRCA_RS1;
                o_alu_src_b   = SRCB_IMM;
                o_alu_control = w_alu_op;
            end
            ALU_WB:  o_reg_write = 1'b1;
            MEM_ADR: begin
                o_alu_src_a = SRCA_RS1;
                o_alu_src_b = SRCB_IMM;
                o_imm_src   = (i_opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            MEM_RD: begin
                o_mem_read = 1'b1;
                o_adr_src  = 1'b1;
            end
            MEM_WB: begin
                o_reg_write  = 1'b1;
                o_result_src = RES_MEM;
            end
            MEM_WR: begin
                o_mem_write = 1'b1;
                o_adr_src   = 1'b1;
            end
            BEQ: begin
                o_alu_src_a   = SRCA_RS1;
                o_alu_control = ALU_SUB;
                o_pc_write    = i_zero;
            end
            default: ;
        endcase
        // reset must drop strobes immediately, before the next clock edge
        if (i_rst) begin
            o_pc_write  = 1'b0;
            o_ir_write  = 1'b0;
            o_mem_read  = 1'b0;
            o_mem_write = 1'b0;
            o_reg_write = 1'b0;
        end
    end

    assign o_state   = r_state;
    assign o_illegal = r_illegal;
    assign o_bus_err = r_bus_err;
    assign o_retired = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction table with scoreboard plus corner-case sequences.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    localparam int CNT_W = 3;

    logic             i_clk, i_rst;
    logic [6:0]       i_opcode;
    logic [2:0]       i_funct3;
    logic             i_funct7b5, i_zero, i_mem_ready;
    logic             o_pc_write, o_ir_write, o_adr_src, o_mem_read, o_mem_write, o_reg_write;
    logic [1:0]       o_alu_src_a, o_alu_src_b, o_alu_control, o_result_src, o_imm_src;
    logic [3:0]       o_state;
    logic             o_illegal, o_bus_err;
    logic [CNT_W-1:0] o_retired;

    multicycle_controller #(.CNT_W(CNT_W), .TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct3(i_funct3),
        .i_funct7b5(i_funct7b5), .i_zero(i_zero), .i_mem_ready(i_mem_ready),
        .o_pc_write(o_pc_write), .o_ir_write(o_ir_write), .o_adr_src(o_adr_src),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_reg_write(o_reg_write),
        .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_alu_control(o_alu_control),
        .o_result_src(o_result_src), .o_imm_src(o_imm_src), .o_state(o_state),
        .o_illegal(o_illegal), .o_bus_err(o_bus_err), .o_retired(o_retired)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       f7b5;
        logic       zero;
        int         cycles;
        bit         chk_alu;
        logic [1:0] alu;
        int         regw;
        int         memw;
        int         pcw;
    } vec_t;

    typedef struct {
        int               cycles;
        bit               chk_alu;
        logic [1:0]       alu;
        int               regw;
        int               memw;
        int               pcw;
        logic [CNT_W-1:0] retired;
    } exp_t;

    vec_t             vecs[10];
    exp_t             sb_q[$];
    int               n_total = 0;
    int               n_bad   = 0;
    logic [CNT_W-1:0] m_retired = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
        #1;
    endtask

    // Entered at negedge+1 with the DUT in FETCH; returns at negedge+1 back in FETCH.
    task automatic run_vec(input int idx, input vec_t v);
        exp_t       e, got;
        logic [1:0] alu;
        int         cyc, regw, memw, pcw;
        e.cycles = v.cycles; e.chk_alu = v.chk_alu; e.alu = v.alu;
        e.regw = v.regw; e.memw = v.memw; e.pcw = v.pcw;
        e.retired = m_retired + 1'b1;
        sb_q.push_back(e);
        i_opcode = v.opcode; i_funct3 = v.funct3; i_funct7b5 = v.f7b5;
        i_zero = v.zero; i_mem_ready = 1'b1;
        alu = 2'b00; cyc = 0; regw = 0; memw = 0; pcw = 0;
        #1;
        do begin
            cyc++;
            if (o_reg_write) regw++;
            if (o_mem_write) memw++;
            if (o_pc_write)  pcw++;
            if (o_state == EXEC_R || o_state == EXEC_I) alu = o_alu_control;
            step();
        end while (o_state != FETCH && o_state != ILLEGAL && cyc < 20);
        m_retired = m_retired + 1'b1;
        got.cycles = cyc; got.alu = alu; got.regw = regw; got.memw = memw; got.pcw = pcw;
        got.retired = o_retired;
        if (sb_q.size() == 0) begin
            check($sformatf("v%0d_sb_empty", idx), 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("v%0d_cycles", idx), got.cycles, e.cycles);
            if (e.chk_alu) check($sformatf("v%0d_alu", idx), 32'(got.alu), 32'(e.alu));
            check($sformatf("v%0d_regw", idx), got.regw, e.regw);
            check($sformatf("v%0d_memw", idx), got.memw, e.memw);
            check($sformatf("v%0d_pcw", idx), got.pcw, e.pcw);
            check($sformatf("v%0d_retired", idx), 32'(got.retired), 32'(e.retired));
        end
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1;
        #1;
        check("rst_state", 32'(o_state), 32'(FETCH));
        check("rst_illegal", 32'(o_illegal), 32'd0);
        step();
        i_rst = 1'b0;
        m_retired = '0;
    endtask

    initial begin
        int guard, bad_cyc, rw_seen, pcw_seen, fetch_cyc;
        vecs[0] = '{OP_RTYPE,  3'b000, 1'b0, 1'b0, 4, 1'b1, 2'b00, 1, 0, 1};
        vecs[1] = '{OP_RTYPE,  3'b000, 1'b1, 1'b0, 4, 1'b1, 2'b01, 1, 0, 1};
        vecs[2] = '{OP_RTYPE,  3'b110, 1'b0, 1'b0, 4, 1'b1, 2'b11, 1, 0, 1};
        vecs[3] = '{OP_RTYPE,  3'b111, 1'b0, 1'b0, 4, 1'b1, 2'b10, 1, 0, 1};
        vecs[4] = '{OP_ITYPE,  3'b000, 1'b1, 1'b0, 4, 1'b1, 2'b00, 1, 0, 1};
        vecs[5] = '{OP_ITYPE,  3'b110, 1'b0, 1'b0, 4, 1'b1, 2'b11, 1, 0, 1};
        vecs[6] = '{OP_LOAD,   3'b010, 1'b0, 1'b0, 5, 1'b0, 2'b00, 1, 0, 1};
        vecs[7] = '{OP_STORE,  3'b010, 1'b0, 1'b0, 4, 1'b0, 2'b00, 0, 1, 1};
        vecs[8] = '{OP_BRANCH, 3'b000, 1'b0, 1'b1, 3, 1'b0, 2'b00, 0, 0, 2};
        vecs[9] = '{OP_BRANCH, 3'b000, 1'b0, 1'b0, 3, 1'b0, 2'b00, 0, 0, 1};

        i_rst = 1'b1; i_opcode = OP_RTYPE; i_funct3 = 3'b000; i_funct7b5 = 1'b0;
        i_zero = 1'b0; i_mem_ready = 1'b1;
        step();
        check("reset_state", 32'(o_state), 32'(FETCH));
        check("reset_strobes", {27'd0, o_pc_write, o_ir_write, o_mem_read, o_mem_write, o_reg_write}, 32'd0);
        check("reset_srcb", 32'(o_alu_src_b), 32'(SRCB_FOUR));
        check("reset_result", 32'(o_result_src), 32'(RES_ALU));
        check("reset_retired", 32'(o_retired), 32'd0);
        check("reset_flags", {30'd0, o_illegal, o_bus_err}, 32'd0);
        i_rst = 1'b0;

        // table of instructions; 10 retirements wrap the 3-bit counter
        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // lw with three wait states in MEM_RD
        i_opcode = OP_LOAD; i_funct3 = 3'b010; i_mem_ready = 1'b1;
        guard = 0;
        while (o_state != MEM_RD && guard < 10) begin step(); guard++; end
        check("lw_reach_memrd", 32'(o_state), 32'(MEM_RD));
        for (int k = 0; k < 4; k++) begin
            i_mem_ready = (k == 3);
            #1;
            check($sformatf("lw_stall%0d", k), {29'd0, o_state == MEM_RD, o_mem_read, o_adr_src}, 32'd7);
            step();
        end
        check("lw_memwb_state", 32'(o_state), 32'(MEM_WB));
        check("lw_memwb_ctl", {29'd0, o_reg_write, o_result_src}, {29'd0, 1'b1, RES_MEM});
        step();
        m_retired = m_retired + 1'b1;
        check("lw_retired", 32'(o_retired), 32'(m_retired));

        // unsupported funct3 in EXEC_R must trap without a register write
        i_opcode = OP_RTYPE; i_funct3 = 3'b001; #1;
        guard = 0; rw_seen = 0;
        while (o_state != ILLEGAL && guard < 10) begin
            if (o_reg_write) rw_seen++;
            step(); guard++;
        end
        check("badf3_state", 32'(o_state), 32'(ILLEGAL));
        check("badf3_flags", {30'd0, o_illegal, o_bus_err}, 32'd2);
        check("badf3_regw", rw_seen, 0);
        pulse_reset();

        // illegal opcode: terminal, strobes silent for 20 cycles
        i_opcode = 7'b1111111; i_funct3 = 3'b000; i_mem_ready = 1'b1; i_zero = 1'b1;
        step(); step();
        check("illop_state", 32'(o_state), 32'(ILLEGAL));
        bad_cyc = 0;
        for (int k = 0; k < 20; k++) begin
            if (o_state != ILLEGAL || !o_illegal || o_pc_write || o_ir_write ||
                o_mem_read || o_mem_write || o_reg_write) bad_cyc++;
            step();
        end
        check("illop_hold", bad_cyc, 0);
        pulse_reset();

        // async reset mid-FETCH and mid-ALU_WB drops strobes without a clock
        i_opcode = OP_RTYPE; i_funct3 = 3'b000; i_zero = 1'b0; #1;
        check("midrst_pre_ir", 32'(o_ir_write), 32'd1);
        #1; i_rst = 1'b1; #1;
        check("midrst_fetch_strobes", {29'd0, o_ir_write, o_pc_write, o_mem_read}, 32'd0);
        step(); i_rst = 1'b0;
        step(); step(); step();
        check("midrst_pre_wb", 32'(o_state), 32'(ALU_WB));
        #1; i_rst = 1'b1; #1;
        check("midrst_wb_state", 32'(o_state), 32'(FETCH));
        check("midrst_wb_regw", 32'(o_reg_write), 32'd0);
        check("midrst_wb_retired", 32'(o_retired), 32'd0);
        step(); i_rst = 1'b0; m_retired = '0;

        // watchdog: FETCH starved of mem_ready
        i_mem_ready = 1'b0; #1;
        fetch_cyc = 0; pcw_seen = 0; guard = 0;
        while (o_state == FETCH && guard < 40) begin
            fetch_cyc++;
            if (o_pc_write || o_ir_write) pcw_seen++;
            step(); guard++;
        end
        check("wd_wait_cycles", fetch_cyc, 16);
        check("wd_state", 32'(o_state), 32'(ILLEGAL));
        check("wd_flags", {30'd0, o_illegal, o_bus_err}, 32'd3);
        check("wd_pcw", pcw_seen, 0);
        pulse_reset();
        check("wd_clear", 32'(o_bus_err), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
